// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep capture engine: FSM states,
// MISR polynomial and maximal-length LFSR tap table.
package sweep_pkg;

  localparam int unsigned SIG_W     = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_STALL  = 3'd3,
    ST_DONE   = 3'd4
  } sweep_state_e;

  // Fibonacci taps, bit n-1 is the MSB; new LSB = ^(state & taps)
  function automatic logic [15:0] lfsr_taps(input int n);
    case (n)
      2:       return 16'h0003;
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0003;
    endcase
  endfunction

endpackage

// File: rtl/sweep_capture_engine_if.sv
// Capture-FIFO read port: valid/ready handshake with the head entry payload.
interface sweep_capture_engine_if #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 1
) ();
  logic             cap_valid;
  logic             cap_ready;
  logic [N_IN-1:0]  cap_pattern;
  logic [N_OUT-1:0] cap_resp;

  modport master (output cap_valid, output cap_pattern, output cap_resp, input cap_ready);
  modport slave  (input cap_valid, input cap_pattern, input cap_resp, output cap_ready);
endinterface

// File: rtl/sweep_fifo.sv
// First-word fall-through FIFO; push and pop may coincide at any occupancy,
// including full. Head data reads as zero while empty.
module sweep_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_en, pop_en;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign rdata   = empty ? '0 : mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_en) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + AW'(1);
    end
    if (pop_en) rd_d = rd_q + AW'(1);
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sweep_capture_engine.sv
// Sweeps the N_IN-bit stimulus space (count or LFSR order) into a DUT, captures
// each settled response into a FIFO and folds it into a 16-bit MISR.
module sweep_capture_engine
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 abort,
  output logic [N_IN-1:0]      stim_o,
  input  logic [N_OUT-1:0]     resp_i,
  sweep_capture_engine_if.master cap,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_W-1:0]     signature
);
  localparam int unsigned     SCW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [N_IN-1:0] ALL_ONES    = '1;
  localparam logic [N_IN-1:0] TAPS        = N_IN'(lfsr_taps(int'(N_IN)));

  sweep_state_e            state_q, state_d;
  logic [N_IN-1:0]         stim_q, stim_d;
  logic                    mode_q, mode_d;
  logic [SCW-1:0]          cnt_q, cnt_d;
  logic [SIG_W-1:0]        sig_q, sig_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [N_IN-1:0]         lfsr_next, pat_next;
  logic                    is_last, pop_c, push_c, can_push;
  logic [SIG_W-1:0]        misr_next;
  logic                    fifo_full, fifo_empty;
  logic [N_IN+N_OUT-1:0]   head;

  assign lfsr_next = {stim_q[N_IN-2:0], ^(stim_q & TAPS)};
  assign pat_next  = mode_q ? lfsr_next : (stim_q + N_IN'(1));
  // LFSR sweep ends on the state whose successor is the all-ones seed
  assign is_last   = mode_q ? (lfsr_next == ALL_ONES) : (stim_q == ALL_ONES);
  assign misr_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? MISR_POLY : '0)
                   ^ SIG_W'(resp_i);
  assign pop_c     = cap.cap_ready & ~fifo_empty;
  assign can_push  = ~fifo_full | pop_c;

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    push_c  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mode_d  = mode;
            stim_d  = mode ? ALL_ONES : '0;
            sig_d   = '0;
            cnt_d   = '0;
            state_d = ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = ST_SAMPLE;
          end else begin
            cnt_d = cnt_q + SCW'(1);
          end
        end
        ST_SAMPLE, ST_STALL: begin
          if (can_push) begin
            push_c = 1'b1;
            sig_d  = misr_next;
            if (is_last) begin
              state_d = ST_DONE;
            end else begin
              stim_d  = pat_next;
              state_d = ST_APPLY;
            end
          end else begin
            state_d = ST_STALL;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_APPLY) || (state_d == ST_SAMPLE) || (state_d == ST_STALL);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      stim_q  <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      sig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  sweep_fifo #(
    .WIDTH (N_IN + N_OUT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CK),
    .rst_n (reset),
    .push  (push_c),
    .wdata ({stim_q, resp_i}),
    .pop   (pop_c),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign stim_o          = stim_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign signature       = sig_q;
  assign cap.cap_valid   = ~fifo_empty;
  assign cap.cap_pattern = head[N_IN+N_OUT-1:N_OUT];
  assign cap.cap_resp    = head[N_OUT-1:0];

endmodule

// File: tb/tb_sweep_capture_engine.sv
// Scoreboard bench: three engine configurations, expected capture entries queued
// at stimulus time and compared by per-instance monitors on each FIFO pop.
module tb_sweep_capture_engine;

  logic CK    = 1'b0;
  logic reset = 1'b0;
  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] pat;
    logic [15:0] resp;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  logic [7:0] par_tab = 8'b1001_0110;
  logic [2:0] lf_tab [7];

  // A: N_IN=3 N_OUT=1 SETTLE=1 DEPTH=8, response = parity
  logic        start_a = 1'b0, mode_a = 1'b0, abort_a = 1'b0;
  logic [2:0]  stim_a;
  logic        resp_a, busy_a, done_a;
  logic [15:0] sig_a;
  sweep_capture_engine_if #(.N_IN(3), .N_OUT(1)) if_a ();
  assign resp_a = ^stim_a;
  sweep_capture_engine #(.N_IN(3), .N_OUT(1), .SETTLE(1), .DEPTH(8)) u_a (
    .CK(CK), .reset(reset), .start(start_a), .mode(mode_a), .abort(abort_a),
    .stim_o(stim_a), .resp_i(resp_a), .cap(if_a), .busy(busy_a), .done(done_a),
    .signature(sig_a));

  // B: as A but DEPTH=4
  logic        start_b = 1'b0, mode_b = 1'b0, abort_b = 1'b0;
  logic [2:0]  stim_b;
  logic        resp_b, busy_b, done_b;
  logic [15:0] sig_b;
  sweep_capture_engine_if #(.N_IN(3), .N_OUT(1)) if_b ();
  assign resp_b = ^stim_b;
  sweep_capture_engine #(.N_IN(3), .N_OUT(1), .SETTLE(1), .DEPTH(4)) u_b (
    .CK(CK), .reset(reset), .start(start_b), .mode(mode_b), .abort(abort_b),
    .stim_o(stim_b), .resp_i(resp_b), .cap(if_b), .busy(busy_b), .done(done_b),
    .signature(sig_b));

  // C: N_IN=4 N_OUT=4 SETTLE=3; response settles to stim+1 only after 3 held cycles
  logic        start_c = 1'b0, mode_c = 1'b0, abort_c = 1'b0;
  logic [3:0]  stim_c, resp_c;
  logic        busy_c, done_c;
  logic [15:0] sig_c;
  logic [3:0]  prev_c = 4'h0;
  int          age_c  = 100;
  sweep_capture_engine_if #(.N_IN(4), .N_OUT(4)) if_c ();
  assign resp_c = (age_c >= 3) ? 4'(stim_c + 4'd1) : ~4'(stim_c + 4'd1);
  sweep_capture_engine #(.N_IN(4), .N_OUT(4), .SETTLE(3), .DEPTH(8)) u_c (
    .CK(CK), .reset(reset), .start(start_c), .mode(mode_c), .abort(abort_c),
    .stim_o(stim_c), .resp_i(resp_c), .cap(if_c), .busy(busy_c), .done(done_c),
    .signature(sig_c));

  initial forever begin
    @(negedge CK);
    if (stim_c != prev_c) begin
      prev_c = stim_c;
      age_c  = 0;
    end else begin
      age_c = age_c + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic sb_cmp(input string tag, input int qsize, input exp_t e,
                        input logic [15:0] pat, input logic [15:0] resp);
    checks++;
    if (qsize == 0) begin
      errors++;
      $display("FAIL %s_unexpected: popped pattern %0h resp %0h, required no entry", tag, pat, resp);
    end else if (pat !== e.pat || resp !== e.resp) begin
      errors++;
      $display("FAIL %s_entry: got pattern %0h resp %0h, required pattern %0h resp %0h",
               tag, pat, resp, e.pat, e.resp);
    end
  endtask

  initial forever begin
    exp_t e;
    int   n;
    @(negedge CK);
    if (if_a.cap_valid && if_a.cap_ready) begin
      e = '0; n = q_a.size();
      if (n != 0) e = q_a.pop_front();
      sb_cmp("A", n, e, 16'(if_a.cap_pattern), 16'(if_a.cap_resp));
    end
  end

  initial forever begin
    exp_t e;
    int   n;
    @(negedge CK);
    if (if_b.cap_valid && if_b.cap_ready) begin
      e = '0; n = q_b.size();
      if (n != 0) e = q_b.pop_front();
      sb_cmp("B", n, e, 16'(if_b.cap_pattern), 16'(if_b.cap_resp));
    end
  end

  initial forever begin
    exp_t e;
    int   n;
    @(negedge CK);
    if (if_c.cap_valid && if_c.cap_ready) begin
      e = '0; n = q_c.size();
      if (n != 0) e = q_c.pop_front();
      sb_cmp("C", n, e, 16'(if_c.cap_pattern), 16'(if_c.cap_resp));
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  function automatic logic get_done(input int w);
    case (w)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic wait_done(input int w, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!get_done(w) && n < limit);
    check($sformatf("done_seen_%0d", w), 32'(get_done(w)), 32'd1);
  endtask

  task automatic exp_push(input int w, input logic [15:0] p, input logic [15:0] r);
    exp_t e;
    e.pat  = p;
    e.resp = r;
    case (w)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic exp_count8(input int w);
    for (int i = 0; i < 8; i++) exp_push(w, 16'(i), 16'(par_tab[i]));
  endtask

  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [15:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic [15:0] s;
    logic [15:0] r;
    lf_tab = '{3'd7, 3'd6, 3'd4, 3'd1, 3'd2, 3'd5, 3'd3};
    if_a.cap_ready = 1'b0;
    if_b.cap_ready = 1'b0;
    if_c.cap_ready = 1'b0;

    // reset values
    repeat (3) tick();
    check("rst_stim", 32'(stim_a), 32'd0);
    check("rst_sig", 32'(sig_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_cap_valid", 32'(if_a.cap_valid), 32'd0);
    check("rst_cap_pattern", 32'(if_a.cap_pattern), 32'd0);
    check("rst_cap_resp", 32'(if_c.cap_resp), 32'd0);
    reset = 1'b1;
    repeat (3) tick();
    check("idle_no_start", 32'(busy_a), 32'd0);

    // count mode, always ready
    exp_count8(0);
    if_a.cap_ready = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t1_busy", 32'(busy_a), 32'd1);
    check("t1_stim0", 32'(stim_a), 32'd0);
    wait_done(0, 100, n);
    check("t1_done_lat", 32'(n), 32'd16);
    check("t1_busy_end", 32'(busy_a), 32'd0);
    check("t1_sig", 32'(sig_a), 32'h0069);
    check("t1_stim_last", 32'(stim_a), 32'd7);
    repeat (4) tick();
    check("t1_done_held", 32'(done_a), 32'd1);
    check("t1_fifo_drained", 32'(if_a.cap_valid), 32'd0);
    check("t1_q_left", 32'(q_a.size()), 32'd0);

    // LFSR mode; mode dropped right after start must not matter
    for (int i = 0; i < 7; i++) exp_push(0, 16'(lf_tab[i]), 16'(par_tab[lf_tab[i]]));
    mode_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    mode_a = 1'b0;
    check("t2_first", 32'(stim_a), 32'd7);
    check("t2_done_clr", 32'(done_a), 32'd0);
    check("t2_sig_clr", 32'(sig_a), 32'd0);
    wait_done(0, 100, n);
    check("t2_done_lat", 32'(n), 32'd14);
    check("t2_sig", 32'(sig_a), 32'h005C);
    check("t2_stim_last", 32'(stim_a), 32'd3);
    repeat (4) tick();
    check("t2_q_left", 32'(q_a.size()), 32'd0);

    // backpressure on DEPTH=4
    exp_count8(1);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (30) tick();
    check("t3_busy", 32'(busy_b), 32'd1);
    check("t3_stim_held", 32'(stim_b), 32'd4);
    check("t3_cap_valid", 32'(if_b.cap_valid), 32'd1);
    check("t3_head", 32'(if_b.cap_pattern), 32'd0);
    check("t3_sig_partial", 32'(sig_b), 32'h0006);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("t3_start_ignored", 32'(stim_b), 32'd4);
    if_b.cap_ready = 1'b1;
    wait_done(1, 100, n);
    check("t3_sig", 32'(sig_b), 32'h0069);
    repeat (6) tick();
    check("t3_q_left", 32'(q_b.size()), 32'd0);
    check("t3_drained", 32'(if_b.cap_valid), 32'd0);

    // SETTLE=3, 4-bit response that settles late
    s = 16'h0;
    for (int i = 0; i < 16; i++) begin
      r = 16'((i + 1) & 15);
      exp_push(2, 16'(i), r);
      s = misr_ref(s, r);
    end
    if_c.cap_ready = 1'b1;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check("t4_stim0", 32'(stim_c), 32'd0);
    wait_done(2, 200, n);
    check("t4_done_lat", 32'(n), 32'd64);
    check("t4_sig", 32'(sig_c), 32'(s));
    check("t4_stim_last", 32'(stim_c), 32'd15);
    repeat (6) tick();
    check("t4_q_left", 32'(q_c.size()), 32'd0);

    // abort during vector 3, then restart
    if_a.cap_ready = 1'b0;
    for (int i = 0; i < 3; i++) exp_push(0, 16'(i), 16'(par_tab[i]));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (6) tick();
    check("t5_vec3", 32'(stim_a), 32'd3);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("t5_busy", 32'(busy_a), 32'd0);
    check("t5_done", 32'(done_a), 32'd0);
    check("t5_stim_kept", 32'(stim_a), 32'd3);
    check("t5_sig_kept", 32'(sig_a), 32'h0003);
    repeat (3) tick();
    check("t5_stays_idle", 32'(busy_a), 32'd0);
    if_a.cap_ready = 1'b1;
    repeat (4) tick();
    check("t5_three_entries", 32'(q_a.size()), 32'd0);
    check("t5_drained", 32'(if_a.cap_valid), 32'd0);
    exp_count8(0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t5_restart_stim", 32'(stim_a), 32'd0);
    check("t5_restart_sig", 32'(sig_a), 32'd0);
    wait_done(0, 100, n);
    check("t5_done_lat", 32'(n), 32'd16);
    check("t5_sig", 32'(sig_a), 32'h0069);
    repeat (3) tick();
    abort_a = 1'b1;
    start_a = 1'b1;
    tick();
    abort_a = 1'b0;
    start_a = 1'b0;
    check("t5_abort_wins_done", 32'(done_a), 32'd0);
    check("t5_abort_wins_busy", 32'(busy_a), 32'd0);
    check("t5_abort_wins_stim", 32'(stim_a), 32'd7);
    check("t5_q_left", 32'(q_a.size()), 32'd0);

    // async reset while stalled
    if_b.cap_ready = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (20) tick();
    check("t6_stalled", 32'(stim_b), 32'd4);
    #3;
    reset = 1'b0;
    #1;
    check("t6_stim", 32'(stim_b), 32'd0);
    check("t6_sig", 32'(sig_b), 32'd0);
    check("t6_busy", 32'(busy_b), 32'd0);
    check("t6_done", 32'(done_b), 32'd0);
    check("t6_cap_valid", 32'(if_b.cap_valid), 32'd0);
    check("t6_cap_pattern", 32'(if_b.cap_pattern), 32'd0);
    check("t6_cap_resp", 32'(if_b.cap_resp), 32'd0);
    tick();
    reset = 1'b1;
    repeat (10) tick();
    check("t6_quiet_busy", 32'(busy_b), 32'd0);
    check("t6_quiet_stim", 32'(stim_b), 32'd0);
    check("t6_quiet_valid", 32'(if_b.cap_valid), 32'd0);
    exp_count8(1);
    if_b.cap_ready = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_done(1, 100, n);
    check("t6_done_lat", 32'(n), 32'd16);
    check("t6_sig", 32'(sig_b), 32'h0069);
    repeat (4) tick();
    check("t6_q_left", 32'(q_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
